// File: rtl/morse_pkg.sv
// Shared types, timing multipliers and the BCD digit code table for the Morse keyer.
package morse_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MARK     = 2'd1,
    SPACE    = 2'd2,
    CHAR_GAP = 2'd3
  } morse_state_t;

  localparam logic DOT  = 1'b0;
  localparam logic DASH = 1'b1;

  localparam int DASH_MULT     = 3;
  localparam int SYM_GAP_MULT  = 1;
  localparam int CHAR_GAP_MULT = 3;
  localparam int DIGIT_LEN     = 5;

  // Morse digits: MSB is the first symbol sent; 0 and non-BCD values give five dashes.
  function automatic logic [4:0] digit_to_code(input logic [3:0] digit);
    logic [4:0] code;
    case (digit)
      4'd1:    code = 5'b01111;
      4'd2:    code = 5'b00111;
      4'd3:    code = 5'b00011;
      4'd4:    code = 5'b00001;
      4'd5:    code = 5'b00000;
      4'd6:    code = 5'b10000;
      4'd7:    code = 5'b11000;
      4'd8:    code = 5'b11100;
      4'd9:    code = 5'b11110;
      default: code = 5'b11111;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/morse_if.sv
// Character offer handshake between a producer and the Morse keyer.
interface morse_if #(
  parameter int MAX_LEN = 5,
  parameter int LEN_W   = 3
);
  logic               in_valid;
  logic               in_ready;
  logic               digit_mode;
  logic [MAX_LEN-1:0] in_code;
  logic [LEN_W-1:0]   in_len;

  modport master (output in_valid, digit_mode, in_code, in_len, input in_ready);
  modport slave  (input in_valid, digit_mode, in_code, in_len, output in_ready);
endinterface

// File: rtl/morse_digit_rom.sv
// Combinational BCD digit to 5-symbol Morse code lookup.
module morse_digit_rom
  import morse_pkg::*;
(
  input  logic [3:0] digit,
  output logic [4:0] code,
  output logic [2:0] len
);

  assign code = digit_to_code(digit);
  assign len  = 3'(DIGIT_LEN);

endmodule

// File: rtl/morse_tx.sv
// Morse keyer: latches one character, then times marks, symbol spaces and the
// character gap in units of UNIT_CYCLES clocks.
module morse_tx
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES = 4,
  parameter int MAX_LEN     = 5,
  parameter int LEN_W       = 3
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   en,
  input  logic   abort,
  morse_if.slave cmd,
  output logic   key_out,
  output logic   busy,
  output logic   char_done
);

  localparam int CNT_W  = $clog2(3 * UNIT_CYCLES + 1);
  localparam int DSHIFT = (MAX_LEN < DIGIT_LEN) ? (DIGIT_LEN - MAX_LEN) : 0;

  localparam logic [CNT_W-1:0] DOT_LAST   = CNT_W'(UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DASH_LAST  = CNT_W'(DASH_MULT * UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] SPACE_LAST = CNT_W'(SYM_GAP_MULT * UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(CHAR_GAP_MULT * UNIT_CYCLES - 1);
  localparam logic [LEN_W-1:0] MAX_LEN_L  = LEN_W'(MAX_LEN);
  localparam logic [MAX_LEN-1:0] ONE_HOT0 = {{(MAX_LEN-1){1'b0}}, 1'b1};

  morse_state_t       state_r, state_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic [LEN_W-1:0]   idx_r, idx_s;
  logic [MAX_LEN-1:0] code_r, code_s;
  logic               key_out_r, busy_r, char_done_r;

  logic [3:0]         digit_s;
  logic [4:0]         rom_code_s;
  logic [2:0]         rom_len_s;
  logic [MAX_LEN-1:0] eff_code_s;
  logic [LEN_W-1:0]   eff_len_s;
  logic               ready_s, accept_s, cur_bit_s;
  logic [CNT_W-1:0]   mark_last_s;

  assign digit_s = 4'(cmd.in_code);

  morse_digit_rom u_digit_rom (
    .digit (digit_s),
    .code  (rom_code_s),
    .len   (rom_len_s)
  );

  assign ready_s      = (state_r == IDLE) & en & ~abort;
  assign cmd.in_ready = ready_s;
  assign accept_s     = cmd.in_valid & ready_s;
  assign cur_bit_s    = |(code_r & (ONE_HOT0 << idx_r));
  assign mark_last_s  = (cur_bit_s == DASH) ? DASH_LAST : DOT_LAST;

  // Effective code/length: digits truncated to the first MAX_LEN symbols, raw lengths clamped.
  always_comb begin
    eff_code_s = '0;
    eff_len_s  = '0;
    if (cmd.digit_mode) begin
      eff_code_s = MAX_LEN'(rom_code_s >> DSHIFT);
      eff_len_s  = (MAX_LEN < DIGIT_LEN) ? MAX_LEN_L : LEN_W'(rom_len_s);
    end else begin
      eff_code_s = cmd.in_code;
      eff_len_s  = (cmd.in_len > MAX_LEN_L) ? MAX_LEN_L : cmd.in_len;
    end
  end

  // Next-state, counter and symbol-index logic; abort overrides every state.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    idx_s   = idx_r;
    code_s  = code_r;
    if (abort) begin
      state_s = IDLE;
      cnt_s   = '0;
      idx_s   = '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            code_s = eff_code_s;
            cnt_s  = '0;
            if (eff_len_s == '0) begin
              state_s = CHAR_GAP;
              idx_s   = '0;
            end else begin
              state_s = MARK;
              idx_s   = eff_len_s - LEN_W'(1);
            end
          end else begin
            state_s = IDLE;
          end
        end
        MARK: begin
          if (cnt_r == mark_last_s) begin
            cnt_s   = '0;
            state_s = (idx_r == '0) ? CHAR_GAP : SPACE;
          end else begin
            cnt_s = cnt_r + CNT_W'(1);
          end
        end
        SPACE: begin
          if (cnt_r == SPACE_LAST) begin
            cnt_s   = '0;
            idx_s   = idx_r - LEN_W'(1);
            state_s = MARK;
          end else begin
            cnt_s = cnt_r + CNT_W'(1);
          end
        end
        CHAR_GAP: begin
          if (cnt_r == GAP_LAST) begin
            cnt_s   = '0;
            state_s = IDLE;
          end else begin
            cnt_s = cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_s = IDLE;
          cnt_s   = '0;
          idx_s   = '0;
        end
      endcase
    end
  end

  // State, counters and outputs registered from the next-state values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      idx_r       <= '0;
      code_r      <= '0;
      key_out_r   <= 1'b0;
      busy_r      <= 1'b0;
      char_done_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      idx_r       <= idx_s;
      code_r      <= code_s;
      key_out_r   <= (state_s == MARK);
      busy_r      <= (state_s != IDLE);
      char_done_r <= (state_s == CHAR_GAP) && (cnt_s == GAP_LAST);
    end
  end

  assign key_out   = key_out_r;
  assign busy      = busy_r;
  assign char_done = char_done_r;

endmodule

// File: tb/tb_morse_tx.sv
// Directed bench for morse_tx with UNIT_CYCLES=2, MAX_LEN=5: key traces and timing.
module tb_morse_tx;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b1;
  logic abort = 1'b0;
  logic key_out, busy, char_done;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  morse_if #(.MAX_LEN(5), .LEN_W(3)) bus ();

  morse_tx #(.UNIT_CYCLES(2), .MAX_LEN(5), .LEN_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .abort     (abort),
    .cmd       (bus),
    .key_out   (key_out),
    .busy      (busy),
    .char_done (char_done)
  );

  always #5 clk = ~clk;

  // Expected key trace (bit c = key_out on cycle c after acceptance); dot 2, dash 6, space 2, gap 6.
  task automatic build_exp(input string syms, output logic [127:0] keys, output int total);
    int c = 1;
    keys = '0;
    for (int i = 0; i < syms.len(); i++) begin
      int m = (syms[i] == "-") ? 6 : 2;
      for (int j = 0; j < m; j++) begin
        keys[c] = 1'b1;
        c++;
      end
      if (i < syms.len() - 1) c += 2;
    end
    c += 6;
    total = c - 1;
  endtask

  // Starts at a negedge that is cycle 1; stops at the negedge where char_done is seen.
  task automatic capture(output logic [127:0] keys, output int done_cyc, output int busy_drop);
    keys = '0;
    done_cyc = 0;
    busy_drop = 0;
    for (int c = 1; c <= 120; c++) begin
      keys[c] = key_out;
      if (busy !== 1'b1) busy_drop++;
      if (char_done === 1'b1) begin
        done_cyc = c;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic send(input logic dm, input logic [4:0] code, input logic [2:0] len);
    @(negedge clk);
    bus.digit_mode = dm;
    bus.in_code = code;
    bus.in_len = len;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset;
    #3;
    total_cnt++;
    if ({key_out, busy, char_done} !== 3'b000) $display("FAIL reset_outputs: got %b expected 000", {key_out, busy, char_done});
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b1;
    #1;
    total_cnt++;
    if (bus.in_ready !== 1'b1) $display("FAIL ready_after_reset: got %b expected 1", bus.in_ready);
    else pass_cnt++;
    en = 1'b0;
    #1;
    total_cnt++;
    if (bus.in_ready !== 1'b0) $display("FAIL ready_en_low: got %b expected 0", bus.in_ready);
    else pass_cnt++;
    en = 1'b1;
  endtask

  task automatic test_char(input string name, input logic dm, input logic [4:0] code,
                           input logic [2:0] len, input string syms, input int hand_total);
    logic [127:0] got, exp;
    int done_cyc, drop, total;
    build_exp(syms, exp, total);
    send(dm, code, len);
    capture(got, done_cyc, drop);
    total_cnt++;
    if (got !== exp) $display("FAIL %s_trace: got %h expected %h", name, got, exp);
    else pass_cnt++;
    total_cnt++;
    if (done_cyc != hand_total) $display("FAIL %s_done_cycle: got %0d expected %0d", name, done_cyc, hand_total);
    else pass_cnt++;
    total_cnt++;
    if (drop != 0) $display("FAIL %s_busy: got %0d idle cycles expected 0", name, drop);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({busy, key_out, char_done} !== 3'b000) $display("FAIL %s_idle_after: got %b expected 000", name, {busy, key_out, char_done});
    else pass_cnt++;
  endtask

  task automatic test_abort;
    int done_seen = 0;
    send(1'b0, 5'b00001, 3'd1);
    @(negedge clk);
    @(negedge clk);
    total_cnt++;
    if (key_out !== 1'b1) $display("FAIL abort_pre_mark: got %b expected 1", key_out);
    else pass_cnt++;
    abort = 1'b1;
    @(negedge clk);
    total_cnt++;
    if ({key_out, busy, char_done} !== 3'b000) $display("FAIL abort_next: got %b expected 000", {key_out, busy, char_done});
    else pass_cnt++;
    bus.digit_mode = 1'b1;
    bus.in_code = 5'd5;
    bus.in_valid = 1'b1;
    #1;
    total_cnt++;
    if (bus.in_ready !== 1'b0) $display("FAIL abort_ready: got %b expected 0", bus.in_ready);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({key_out, busy} !== 2'b00) $display("FAIL abort_no_accept: got %b expected 00", {key_out, busy});
    else pass_cnt++;
    abort = 1'b0;
    bus.in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (char_done === 1'b1) done_seen++;
      @(negedge clk);
    end
    total_cnt++;
    if (done_seen != 0) $display("FAIL abort_no_done: got %0d pulses expected 0", done_seen);
    else pass_cnt++;
  endtask

  task automatic test_en_drop;
    logic [127:0] got, exp;
    int done_cyc, drop, total;
    build_exp("..", exp, total);
    send(1'b0, 5'b00000, 3'd2);
    en = 1'b0;
    capture(got, done_cyc, drop);
    total_cnt++;
    if (got !== exp || done_cyc != 12) $display("FAIL en_drop_completes: got %h/%0d expected %h/12", got, done_cyc, exp);
    else pass_cnt++;
    @(negedge clk);
    bus.in_valid = 1'b1;
    #1;
    total_cnt++;
    if (bus.in_ready !== 1'b0) $display("FAIL en_drop_ready: got %b expected 0", bus.in_ready);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL en_drop_no_accept: got %b expected 0", busy);
    else pass_cnt++;
    bus.in_valid = 1'b0;
    en = 1'b1;
  endtask

  task automatic test_reset_mid_mark;
    send(1'b0, 5'b00001, 3'd1);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    total_cnt++;
    if ({key_out, busy} !== 2'b00) $display("FAIL reset_mid_mark: got %b expected 00", {key_out, busy});
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b1;
    #1;
    total_cnt++;
    if (bus.in_ready !== en) $display("FAIL reset_release_ready: got %b expected %b", bus.in_ready, en);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    logic [127:0] got, exp;
    int done_cyc, drop, total;
    @(negedge clk);
    bus.digit_mode = 1'b1;
    bus.in_code = 5'd5;
    bus.in_len = 3'd0;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_code = 5'd1;
    build_exp(".....", exp, total);
    capture(got, done_cyc, drop);
    total_cnt++;
    if (got !== exp || done_cyc != 24) $display("FAIL b2b_first: got %h/%0d expected %h/24", got, done_cyc, exp);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({bus.in_ready, busy, key_out} !== 3'b100) $display("FAIL b2b_idle_cycle: got %b expected 100", {bus.in_ready, busy, key_out});
    else pass_cnt++;
    @(negedge clk);
    bus.in_valid = 1'b0;
    build_exp(".----", exp, total);
    capture(got, done_cyc, drop);
    total_cnt++;
    if (got !== exp || done_cyc != 40) $display("FAIL b2b_second: got %h/%0d expected %h/40", got, done_cyc, exp);
    else pass_cnt++;
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.digit_mode = 1'b0;
    bus.in_code = '0;
    bus.in_len = '0;
    test_reset();
    test_char("digit5", 1'b1, 5'd5, 3'd0, ".....", 24);
    test_char("digit0", 1'b1, 5'd0, 3'd0, "-----", 44);
    test_char("digit12", 1'b1, 5'd12, 3'd0, "-----", 44);
    test_char("raw2", 1'b0, 5'b00010, 3'd2, "-.", 16);
    test_char("raw_clamp", 1'b0, 5'b10110, 3'd7, "-.--.", 36);
    test_char("len0", 1'b0, 5'b11111, 3'd0, "", 6);
    test_abort();
    test_en_drop();
    test_reset_mid_mark();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", pass_cnt, total_cnt);
    $fatal(1);
  end

endmodule
